// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder between NREQ requesters.
// A single registered result slot; a new grant may overwrite it in the cycle it drains.
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_carry,
    output logic [IDW-1:0]        res_id,
    output logic [15:0]           op_count
);

    // Handshake: a request transfers on req_valid[i] & req_ready[i]; the result
    // leaves on res_valid & res_ready. Grants are issued only when the slot is free.

    logic [IDW-1:0]   last_grant;
    logic             slot_free;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             found;
    logic             xfer;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   add_out;

    assign slot_free = !res_valid || res_ready;

    // Two passes: indices above last_grant first, then wrap to 0..last_grant.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        if (ena && slot_free) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (IDW'(i) > last_grant)) begin
                    grant[i] = 1'b1;
                    grant_id = IDW'(i);
                    found    = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (IDW'(i) <= last_grant)) begin
                    grant[i] = 1'b1;
                    grant_id = IDW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = found;

    // One-hot AND-OR operand select keeps operands off the grant path.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
                sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign add_out = {1'b0, sel_a} + {1'b0, sel_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_carry  <= 1'b0;
            res_id     <= '0;
            op_count   <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (xfer) begin
            res_valid  <= 1'b1;
            res_sum    <= add_out[WIDTH-1:0];
            res_carry  <= add_out[WIDTH];
            res_id     <= grant_id;
            op_count   <= op_count + 16'd1;
            last_grant <= grant_id;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: spec-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_adder_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  ena;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_carry;
    logic [IDW-1:0]        res_id;
    logic [15:0]           op_count;

    int checks = 0;
    int errors = 0;

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_carry(res_carry), .res_id(res_id), .op_count(op_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    logic [IDW+WIDTH:0] exp_q[$];   // {id, carry, sum} of a result due next cycle
    bit                 m_valid;
    logic [WIDTH-1:0]   m_sum;
    logic               m_carry;
    logic [IDW-1:0]     m_id;
    int                 m_count;
    int                 m_last;

    function automatic logic [NREQ-1:0] model_grant();
        logic [NREQ-1:0] g;
        int              idx;
        g = '0;
        if (ena && (!m_valid || res_ready)) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (g == '0 && req_valid[idx]) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    always begin : compare
        logic [NREQ-1:0]    exp_ready;
        logic [IDW+WIDTH:0] ent;
        logic [WIDTH:0]     full;
        int                 gi;
        @(negedge clk);
        #3;
        if (!rst_n) begin
            exp_q.delete();
            m_valid = 0; m_sum = '0; m_carry = 0; m_id = '0;
            m_count = 0; m_last = NREQ - 1;
        end else if (exp_q.size() > 0) begin
            ent     = exp_q.pop_front();
            m_valid = 1;
            m_id    = ent[IDW+WIDTH:WIDTH+1];
            m_carry = ent[WIDTH];
            m_sum   = ent[WIDTH-1:0];
        end
        exp_ready = model_grant();
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("res_valid", 32'(res_valid), 32'(m_valid));
        check("res_sum",   32'(res_sum),   32'(m_sum));
        check("res_carry", 32'(res_carry), 32'(m_carry));
        check("res_id",    32'(res_id),    32'(m_id));
        check("op_count",  32'(op_count),  32'(m_count));
        if (rst_n) begin
            gi = -1;
            for (int i = 0; i < NREQ; i++) if (exp_ready[i]) gi = i;
            if (gi >= 0) begin
                full = 9'(req_a[gi*WIDTH +: WIDTH]) + 9'(req_b[gi*WIDTH +: WIDTH]);
                exp_q.push_back({IDW'(gi), full});
                m_count = (m_count + 1) % 65536;
                m_last  = gi;
            end else if (m_valid && res_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int n;
        int snap;
        rst_n = 0; ena = 1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1;
        repeat (2) tick();
        check("reset res_valid", 32'(res_valid), 32'h0);
        check("reset op_count",  32'(op_count),  32'h0);
        check("reset res_sum",   32'(res_sum),   32'h0);
        rst_n = 1;
        tick();

        // single request from requester 0
        req_valid = 4'b0001; set_op(0, 8'h12, 8'h34);
        #1 check("t1 req_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        #1;
        check("t1 res_valid", 32'(res_valid), 32'h1);
        check("t1 res_sum",   32'(res_sum),   32'h46);
        check("t1 res_carry", 32'(res_carry), 32'h0);
        check("t1 res_id",    32'(res_id),    32'h0);
        check("t1 op_count",  32'(op_count),  32'h1);

        // all requesters valid: rotation continues after last grant (0)
        for (int i = 0; i < NREQ; i++) set_op(i, 8'(i * 8'h11), 8'h20);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr req_ready", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
            if (k > 0) check("rr res_id", 32'(res_id), 32'(k % 4));
            tick();
        end

        // carry cases through requester 0
        req_valid = 4'b0001; set_op(0, 8'hFF, 8'h01);
        tick();
        set_op(0, 8'hC8, 8'h64);
        #1;
        check("carry ff+01 sum", 32'(res_sum), 32'h00);
        check("carry ff+01 c",   32'(res_carry), 32'h1);
        tick();
        set_op(0, 8'h80, 8'h80);
        #1;
        check("carry c8+64 sum", 32'(res_sum), 32'h2C);
        check("carry c8+64 c",   32'(res_carry), 32'h1);
        tick();
        req_valid = '0;
        #1;
        check("carry 80+80 sum", 32'(res_sum), 32'h00);
        check("carry 80+80 c",   32'(res_carry), 32'h1);
        tick();

        // backpressure: fill slot from requester 3, then stall with 1 and 2 waiting
        req_valid = 4'b1000; set_op(3, 8'h05, 8'h06);
        tick();
        res_ready = 0; req_valid = 4'b0110;
        set_op(1, 8'h30, 8'h0F); set_op(2, 8'hA0, 8'h70);
        repeat (3) begin
            #1;
            check("bp req_ready", 32'(req_ready), 32'h0);
            check("bp res_id",    32'(res_id),    32'h3);
            check("bp res_sum",   32'(res_sum),   32'h0B);
            check("bp res_valid", 32'(res_valid), 32'h1);
            tick();
        end
        res_ready = 1;
        #1 check("bp release grant", 32'(req_ready), 32'b0010);
        tick();
        #1;
        check("bp no bubble valid", 32'(res_valid), 32'h1);
        check("bp new res_id",      32'(res_id),    32'h1);
        check("bp new res_sum",     32'(res_sum),   32'h3F);

        // ena low: pending result drains, no grants, counter frozen
        ena = 0; req_valid = 4'b1111;
        snap = m_count;
        #1 check("ena0 req_ready", 32'(req_ready), 32'h0);
        tick();
        #1;
        check("ena0 drained",  32'(res_valid), 32'h0);
        check("ena0 op_count", 32'(op_count),  32'(snap));
        tick();
        ena = 1;
        #1 check("ena1 resume grant", 32'(req_ready), 32'b0100);
        tick();

        // counter wrap
        req_valid = 4'b0001; set_op(0, 8'h01, 8'h02);
        n = 65535 - m_count;
        repeat (n) tick();
        #1 check("wrap ffff", 32'(op_count), 32'hFFFF);
        tick();
        #1 check("wrap 0000", 32'(op_count), 32'h0000);

        // asynchronous reset mid-stream
        req_valid = 4'b1111;
        tick();
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("async rst res_valid", 32'(res_valid), 32'h0);
        check("async rst op_count",  32'(op_count),  32'h0);
        req_valid = 4'b1100;
        tick();
        tick();
        rst_n = 1;
        #1 check("post rst grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        check("post rst res_id",   32'(res_id),   32'h2);
        check("post rst op_count", 32'(op_count), 32'h1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
